rdmx_tx_arbiter: RTL and testbench

- Packet-level 2:1 AXI-Stream arbiter placed directly downstream of the RDMX transmit path, ahead of the Ethernet MAC TX port.
- Channel 0 carries finished RDMX/UDP packets from the transmitter. Channel 1 carries auxiliary frames, such as ARP or ICMP replies.
- Interleaving happens only at packet boundaries. The output is a registered skid slice, so timing into the MAC is clean.
- Per-channel packet counters feed status registers.

---
 rtl/rdmx_pkg.sv | 16 +
 rtl/rdmx_axis_skid.sv | 69 ++++++
 rtl/rdmx_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_rdmx_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdmx_pkg.sv
// Shared encodings for the RDMX transmit arbiter slice.
// State codes double as the active_chan status value.
package rdmx_pkg;

  localparam int DATA_WBITS_DEF = 512;

  localparam logic CH_RDMX = 1'b0;
  localparam logic CH_AUX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rdmx_axis_skid.sv
// Two-entry AXI-Stream register slice: one output register plus
// one skid register so upstream ready is fully registered.
module rdmx_axis_skid
  import rdmx_pkg::*;
#(
  parameter int DATA_WBITS = DATA_WBITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WBITS-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WBITS/8-1:0] S_AXIS_TKEEP,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  output logic [DATA_WBITS-1:0]   M_AXIS_TDATA,
  output logic [DATA_WBITS/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY
);

  localparam int KW = DATA_WBITS / 8;

  logic [DATA_WBITS-1:0] sk_data;
  logic [KW-1:0]         sk_keep;
  logic                  sk_last;
  logic                  sk_valid;
  logic                  out_free;
  logic                  s_fire;

  assign S_AXIS_TREADY = !sk_valid;
  assign out_free      = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (reset) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_keep       <= '0;
      sk_last       <= 1'b0;
    end else if (out_free) begin
      // the skid entry is older than anything at the input
      if (sk_valid) begin
        M_AXIS_TDATA  <= sk_data;
        M_AXIS_TKEEP  <= sk_keep;
        M_AXIS_TLAST  <= sk_last;
        M_AXIS_TVALID <= 1'b1;
        sk_valid      <= 1'b0;
      end else if (s_fire) begin
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TKEEP  <= S_AXIS_TKEEP;
        M_AXIS_TLAST  <= S_AXIS_TLAST;
        M_AXIS_TVALID <= 1'b1;
      end else begin
        M_AXIS_TVALID <= 1'b0;
      end
    end else if (s_fire) begin
      sk_data  <= S_AXIS_TDATA;
      sk_keep  <= S_AXIS_TKEEP;
      sk_last  <= S_AXIS_TLAST;
      sk_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/rdmx_tx_arbiter.sv
// Packet-level 2:1 AXIS arbiter between the RDMX transmitter and
// auxiliary frames, feeding the MAC through a skid slice.
module rdmx_tx_arbiter
  import rdmx_pkg::*;
#(
  parameter int DATA_WBITS  = DATA_WBITS_DEF,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WBITS-1:0]   S0_AXIS_TDATA,
  input  logic [DATA_WBITS/8-1:0] S0_AXIS_TKEEP,
  input  logic                    S0_AXIS_TLAST,
  input  logic                    S0_AXIS_TVALID,
  output logic                    S0_AXIS_TREADY,
  input  logic [DATA_WBITS-1:0]   S1_AXIS_TDATA,
  input  logic [DATA_WBITS/8-1:0] S1_AXIS_TKEEP,
  input  logic                    S1_AXIS_TLAST,
  input  logic                    S1_AXIS_TVALID,
  output logic                    S1_AXIS_TREADY,
  output logic [DATA_WBITS-1:0]   M_AXIS_TDATA,
  output logic [DATA_WBITS/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [31:0]             pkt_count0,
  output logic [31:0]             pkt_count1,
  output logic [1:0]              active_chan
);

  localparam int KW = DATA_WBITS / 8;

  arb_state_e            state;
  logic                  last_grant;
  logic                  sk_ready;
  logic                  sk_valid;
  logic [DATA_WBITS-1:0] sk_data;
  logic [KW-1:0]         sk_keep;
  logic                  sk_last;
  logic                  fire0;
  logic                  fire1;
  logic                  tie_to1;

  assign S0_AXIS_TREADY = (state == ST_GRANT0) && sk_ready;
  assign S1_AXIS_TREADY = (state == ST_GRANT1) && sk_ready;
  assign fire0 = S0_AXIS_TVALID && S0_AXIS_TREADY;
  assign fire1 = S1_AXIS_TVALID && S1_AXIS_TREADY;
  assign active_chan = state;

  // a tie goes to ch1 only when alternating and ch0 went last
  assign tie_to1 = (ROUND_ROBIN != 0) && (last_grant == CH_RDMX);

  always_comb begin
    sk_valid = 1'b0;
    sk_data  = S0_AXIS_TDATA;
    sk_keep  = S0_AXIS_TKEEP;
    sk_last  = S0_AXIS_TLAST;
    unique case (1'b1)
      state == ST_GRANT0: sk_valid = S0_AXIS_TVALID;
      state == ST_GRANT1: begin
        sk_valid = S1_AXIS_TVALID;
        sk_data  = S1_AXIS_TDATA;
        sk_keep  = S1_AXIS_TKEEP;
        sk_last  = S1_AXIS_TLAST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= CH_AUX;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (S0_AXIS_TVALID && S1_AXIS_TVALID)
            state <= tie_to1 ? ST_GRANT1 : ST_GRANT0;
          else if (S0_AXIS_TVALID)
            state <= ST_GRANT0;
          else if (S1_AXIS_TVALID)
            state <= ST_GRANT1;
        end
        ST_GRANT0: begin
          if (fire0 && S0_AXIS_TLAST) begin
            state      <= ST_IDLE;
            last_grant <= CH_RDMX;
            pkt_count0 <= pkt_count0 + 32'd1;
          end
        end
        ST_GRANT1: begin
          if (fire1 && S1_AXIS_TLAST) begin
            state      <= ST_IDLE;
            last_grant <= CH_AUX;
            pkt_count1 <= pkt_count1 + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rdmx_axis_skid #(
    .DATA_WBITS(DATA_WBITS)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .S_AXIS_TDATA (sk_data),
    .S_AXIS_TKEEP (sk_keep),
    .S_AXIS_TLAST (sk_last),
    .S_AXIS_TVALID(sk_valid),
    .S_AXIS_TREADY(sk_ready),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TKEEP (M_AXIS_TKEEP),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY)
  );

endmodule

// File: tb/tb_rdmx_tx_arbiter.sv
// Directed bench for rdmx_tx_arbiter: one round-robin and one
// fixed-priority instance share stimulus, the idle one held in reset.
module tb_rdmx_tx_arbiter;

  localparam int W  = 64;
  localparam int KW = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel, rnd_en;
  logic [W-1:0]  s0_data, s1_data;
  logic [KW-1:0] s0_keep, s1_keep;
  logic s0_last, s1_last, s0_valid, s1_valid;
  logic m_ready;

  logic a_s0_rdy, a_s1_rdy, a_mv, a_ml;
  logic b_s0_rdy, b_s1_rdy, b_mv, b_ml;
  logic [W-1:0]  a_md, b_md;
  logic [KW-1:0] a_mk, b_mk;
  logic [31:0] a_pc0, a_pc1, b_pc0, b_pc1;
  logic [1:0]  a_act, b_act;

  rdmx_tx_arbiter #(.DATA_WBITS(W), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .reset(rst_a),
    .S0_AXIS_TDATA(s0_data), .S0_AXIS_TKEEP(s0_keep),
    .S0_AXIS_TLAST(s0_last), .S0_AXIS_TVALID(s0_valid),
    .S0_AXIS_TREADY(a_s0_rdy),
    .S1_AXIS_TDATA(s1_data), .S1_AXIS_TKEEP(s1_keep),
    .S1_AXIS_TLAST(s1_last), .S1_AXIS_TVALID(s1_valid),
    .S1_AXIS_TREADY(a_s1_rdy),
    .M_AXIS_TDATA(a_md), .M_AXIS_TKEEP(a_mk),
    .M_AXIS_TLAST(a_ml), .M_AXIS_TVALID(a_mv),
    .M_AXIS_TREADY(m_ready),
    .pkt_count0(a_pc0), .pkt_count1(a_pc1),
    .active_chan(a_act)
  );

  rdmx_tx_arbiter #(.DATA_WBITS(W), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .S0_AXIS_TDATA(s0_data), .S0_AXIS_TKEEP(s0_keep),
    .S0_AXIS_TLAST(s0_last), .S0_AXIS_TVALID(s0_valid),
    .S0_AXIS_TREADY(b_s0_rdy),
    .S1_AXIS_TDATA(s1_data), .S1_AXIS_TKEEP(s1_keep),
    .S1_AXIS_TLAST(s1_last), .S1_AXIS_TVALID(s1_valid),
    .S1_AXIS_TREADY(b_s1_rdy),
    .M_AXIS_TDATA(b_md), .M_AXIS_TKEEP(b_mk),
    .M_AXIS_TLAST(b_ml), .M_AXIS_TVALID(b_mv),
    .M_AXIS_TREADY(m_ready),
    .pkt_count0(b_pc0), .pkt_count1(b_pc1),
    .active_chan(b_act)
  );

  logic rst_cur, s0_rdy, s1_rdy, mv, ml;
  logic [W-1:0]  md;
  logic [KW-1:0] mk;
  logic [31:0]   pc0, pc1;
  logic [1:0]    act;

  assign rst_cur = sel ? rst_b : rst_a;
  assign s0_rdy  = sel ? b_s0_rdy : a_s0_rdy;
  assign s1_rdy  = sel ? b_s1_rdy : a_s1_rdy;
  assign mv      = sel ? b_mv : a_mv;
  assign ml      = sel ? b_ml : a_ml;
  assign md      = sel ? b_md : a_md;
  assign mk      = sel ? b_mk : a_mk;
  assign pc0     = sel ? b_pc0 : a_pc0;
  assign pc1     = sel ? b_pc1 : a_pc1;
  assign act     = sel ? b_act : a_act;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_d(int ch, int pkt, int i);
    return 64'hA500_0000_0000_0000 | (64'(ch) << 40) |
           (64'(pkt) << 24) | 64'(i);
  endfunction

  function automatic logic [KW-1:0] beat_k(int i);
    return KW'(i * 17);
  endfunction

  always @(negedge clk)
    m_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [W-1:0]  q_d[$];
  logic [KW-1:0] q_k[$];
  logic          q_l[$];
  int            q_c[$];
  int            rp;

  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_d;
  logic [KW-1:0] prev_k;
  logic          prev_l;
  int            acc0 = 0;
  int            s1_bad = 0;

  // output monitor, sampled between the falling and rising edge
  always @(negedge clk) begin
    #2;
    if (prev_stall) begin
      check("stall_valid", 64'(mv), 64'd1);
      check("stall_data", md, prev_d);
      check("stall_keep", 64'(mk), 64'(prev_k));
      check("stall_last", 64'(ml), 64'(prev_l));
    end
    prev_stall = mv && !m_ready && !rst_cur;
    prev_d = md;
    prev_k = mk;
    prev_l = ml;
    if (mv && m_ready) begin
      q_d.push_back(md);
      q_k.push_back(mk);
      q_l.push_back(ml);
      q_c.push_back(cyc);
    end
    if (s0_valid && s0_rdy && !rst_cur) acc0++;
    if (s0_valid && s1_rdy) s1_bad++;
  end

  task automatic clear_q();
    q_d.delete();
    q_k.delete();
    q_l.delete();
    q_c.delete();
    rp = 0;
  endtask

  // present beats 0..n-1 from a falling edge; returns on a falling edge
  task automatic src(input int ch, input int pkt, input int n);
    logic acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      if (ch == 0) begin
        s0_data  = beat_d(ch, pkt, i);
        s0_keep  = beat_k(i);
        s0_last  = (i == n - 1);
        s0_valid = 1'b1;
      end else begin
        s1_data  = beat_d(ch, pkt, i);
        s1_keep  = beat_k(i);
        s1_last  = (i == n - 1);
        s1_valid = 1'b1;
      end
      guard = 0;
      acc = 1'b0;
      do begin
        #1;
        acc = (ch == 0 ? s0_rdy : s1_rdy) && !rst_cur;
        @(negedge clk);
        guard++;
      end while (!acc && guard < 2000);
      if (!acc) begin
        check("src_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (ch == 0) s0_valid = 1'b0;
    else s1_valid = 1'b0;
  endtask

  task automatic exp_rng(input int ch, input int pkt,
                         input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (rp >= q_d.size()) begin
        check("q_short", 64'(q_d.size()), 64'(rp + 1));
        return;
      end
      check("q_data", q_d[rp], beat_d(ch, pkt, i));
      check("q_keep", 64'(q_k[rp]), 64'(beat_k(i)));
      check("q_last", 64'(q_l[rp]), 64'(i == hi));
      rp++;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    clear_q();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c1_mid;
  int guard;

  initial begin
    sel = 1'b0; rnd_en = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_last = 1'b0; s1_last = 1'b0;
    s0_data = '0; s1_data = '0;
    s0_keep = '0; s1_keep = '0;
    rp = 0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);

    check("rst_mvalid", 64'(mv), 64'd0);
    check("rst_mdata", md, 64'd0);
    check("rst_mkeep", 64'(mk), 64'd0);
    check("rst_mlast", 64'(ml), 64'd0);
    check("rst_s0rdy", 64'(s0_rdy), 64'd0);
    check("rst_s1rdy", 64'(s1_rdy), 64'd0);
    check("rst_pc0", 64'(pc0), 64'd0);
    check("rst_pc1", 64'(pc1), 64'd0);
    check("rst_act", 64'(act), 64'd0);

    // single 4-beat ch0 packet, cycle-exact
    s0_data = beat_d(0, 0, 0);
    s0_keep = beat_k(0);
    s0_last = 1'b0;
    s0_valid = 1'b1;
    check("t1_act_idle", 64'(act), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("t1_act_g0", 64'(act), 64'd1);
        check("t1_s0rdy", 64'(s0_rdy), 64'd1);
        check("t1_mv0", 64'(mv), 64'd0);
      end else begin
        check("t1_mv", 64'(mv), 64'd1);
        check("t1_md", md, beat_d(0, 0, i - 2));
        check("t1_ml", 64'(ml), 64'(i == 5));
      end
      if (i >= 2 && i <= 4) begin
        s0_data = beat_d(0, 0, i - 1);
        s0_keep = beat_k(i - 1);
        s0_last = (i == 4);
      end
      if (i == 5) begin
        s0_valid = 1'b0;
        check("t1_pc0", 64'(pc0), 64'd1);
        check("t1_act_end", 64'(act), 64'd0);
      end
    end
    @(negedge clk);
    check("t1_mv_end", 64'(mv), 64'd0);

    // round-robin with both channels continuously busy
    reset_a();
    fork
      begin src(0, 0, 3); src(0, 1, 3); end
      begin src(1, 0, 3); src(1, 1, 3); end
    join
    repeat (3) @(negedge clk);
    exp_rng(0, 0, 0, 2);
    exp_rng(1, 0, 0, 2);
    exp_rng(0, 1, 0, 2);
    exp_rng(1, 1, 0, 2);
    check("t2_qsize", 64'(q_d.size()), 64'd12);
    if (q_c.size() == 12)
      for (int i = 0; i < 11; i++)
        check("t2_gap", 64'(q_c[i + 1] - q_c[i]),
              64'((i % 3 == 2) ? 2 : 1));
    check("t2_pc0", 64'(pc0), 64'd2);
    check("t2_pc1", 64'(pc1), 64'd2);

    // fixed priority instance
    rst_a = 1'b1;
    sel = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    clear_q();
    s1_bad = 0;
    c1_mid = -1;
    fork
      begin
        src(0, 0, 3);
        src(0, 1, 3);
        c1_mid = int'(pc1);
      end
      src(1, 0, 3);
    join
    repeat (3) @(negedge clk);
    exp_rng(0, 0, 0, 2);
    exp_rng(0, 1, 0, 2);
    exp_rng(1, 0, 0, 2);
    check("t3_s1rdy_while_s0", 64'(s1_bad), 64'd0);
    check("t3_pc1_mid", 64'(c1_mid), 64'd0);
    check("t3_pc0", 64'(pc0), 64'd2);
    check("t3_pc1", 64'(pc1), 64'd1);
    rst_b = 1'b1;
    sel = 1'b0;

    // 16-beat ch1 packet under random backpressure
    reset_a();
    rnd_en = 1'b1;
    src(1, 5, 16);
    repeat (4) @(negedge clk);
    rnd_en = 1'b0;
    repeat (6) @(negedge clk);
    exp_rng(1, 5, 0, 15);
    check("t4_qsize", 64'(q_d.size()), 64'd16);
    check("t4_pc1", 64'(pc1), 64'd1);
    check("t4_pc0", 64'(pc0), 64'd0);

    // reset while beat 5 of an 8-beat ch0 packet is on the bus
    reset_a();
    acc0 = 0;
    fork
      src(0, 0, 8);
      begin
        guard = 0;
        while (acc0 < 4 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        check("t5_reach_beat5", 64'(acc0), 64'd4);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("t5_mv", 64'(mv), 64'd0);
        check("t5_s0rdy", 64'(s0_rdy), 64'd0);
        check("t5_s1rdy", 64'(s1_rdy), 64'd0);
        check("t5_pc0", 64'(pc0), 64'd0);
        check("t5_pc1", 64'(pc1), 64'd0);
        check("t5_act", 64'(act), 64'd0);
        clear_q();
      end
    join
    src(1, 0, 2);
    repeat (3) @(negedge clk);
    exp_rng(0, 0, 4, 7);
    exp_rng(1, 0, 0, 1);
    check("t5_pc0_after", 64'(pc0), 64'd1);
    check("t5_pc1_after", 64'(pc1), 64'd1);

    // counter wrap
    reset_a();
    force dut_a.pkt_count0 = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.pkt_count0;
    @(negedge clk);
    check("t6_preload", 64'(pc0), 64'hFFFF_FFFF);
    src(0, 2, 2);
    repeat (3) @(negedge clk);
    exp_rng(0, 2, 0, 1);
    check("t6_wrap", 64'(pc0), 64'd0);
    check("t6_pc1", 64'(pc1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
